// File: rtl/fpu_wb_stage.sv
// FP writeback stage and f0-f31 register file: commits FPU results and FLW data, stalls on late loads.
// Optional `FPU_WB_BYPASS_EN: read ports return the write in flight this cycle (write-through).
module fpu_wb_stage #(
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rd_temp_f_out_wb,
    input  logic        wb_enable_f_out_wb,
    input  logic [31:0] result_f_wb,
    input  logic        lw_en,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    input  logic [4:0]  rs1_f,
    input  logic [4:0]  rs2_f,
    input  logic [4:0]  rs3_f,
    output logic [31:0] rs1_data_f,
    output logic [31:0] rs2_data_f,
    output logic [31:0] rs3_data_f,
    output logic        stall_wb,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        load_err
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned CW   = 8;

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     pend_rd, pend_rd_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic              err_set;
    logic              wr_en;
    logic [AW-1:0]     wr_rd;
    logic [XLEN-1:0]   wr_data;
    logic [XLEN-1:0]   rf [NREG];

    // Next-state and write-port decode; reset suppresses any commit in the same cycle.
    always_comb begin
        state_nxt   = state;
        pend_rd_nxt = pend_rd;
        cnt_nxt     = cnt;
        err_set     = 1'b0;
        wr_en       = 1'b0;
        wr_rd       = '0;
        wr_data     = '0;
        case (state)
            IDLE: begin
                if (wb_enable_f_out_wb) begin
                    if (!lw_en) begin
                        wr_en   = 1'b1;
                        wr_rd   = rd_temp_f_out_wb;
                        wr_data = result_f_wb;
                    end else if (mem_rdata_valid) begin
                        wr_en   = 1'b1;
                        wr_rd   = rd_temp_f_out_wb;
                        wr_data = mem_rdata;
                    end else begin
                        pend_rd_nxt = rd_temp_f_out_wb;
                        cnt_nxt     = '0;
                        state_nxt   = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rdata_valid) begin
                    wr_en     = 1'b1;
                    wr_rd     = pend_rd;
                    wr_data   = mem_rdata;
                    state_nxt = IDLE;
                end else if (cnt == CW'(LOAD_TIMEOUT)) begin
                    // Counter sat at the limit for one cycle; abort without writing.
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            wr_en   = 1'b0;
            wr_rd   = '0;
            wr_data = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pend_rd  <= '0;
            cnt      <= '0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_rd  <= pend_rd_nxt;
            cnt      <= cnt_nxt;
            load_err <= load_err | err_set;
        end
    end

    // Register file array; f0 is an ordinary register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_rd] <= wr_data;
        end
    end

    assign stall_wb  = (state == LOAD_WAIT) && !mem_rdata_valid;
    assign fwd_valid = wr_en;
    assign fwd_rd    = wr_rd;
    assign fwd_data  = wr_data;

`ifdef FPU_WB_BYPASS_EN
    assign rs1_data_f = (wr_en && (rs1_f == wr_rd)) ? wr_data : rf[rs1_f];
    assign rs2_data_f = (wr_en && (rs2_f == wr_rd)) ? wr_data : rf[rs2_f];
    assign rs3_data_f = (wr_en && (rs3_f == wr_rd)) ? wr_data : rf[rs3_f];
`else
    assign rs1_data_f = rf[rs1_f];
    assign rs2_data_f = rf[rs2_f];
    assign rs3_data_f = rf[rs3_f];
`endif

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Self-checking bench for fpu_wb_stage: random commits against an array model plus directed load/stall/reset scenarios.
module tb_fpu_wb_stage;

    localparam int unsigned LT = 4;
`ifdef FPU_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_temp_f_out_wb;
    logic        wb_enable_f_out_wb;
    logic [31:0] result_f_wb;
    logic        lw_en;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic [4:0]  rs1_f, rs2_f, rs3_f;
    logic [31:0] rs1_data_f, rs2_data_f, rs3_data_f;
    logic        stall_wb;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rf [32];

    always #5 clk = ~clk;

    fpu_wb_stage #(.LOAD_TIMEOUT(LT)) dut (
        .clk                (clk),
        .rst                (rst),
        .rd_temp_f_out_wb   (rd_temp_f_out_wb),
        .wb_enable_f_out_wb (wb_enable_f_out_wb),
        .result_f_wb        (result_f_wb),
        .lw_en              (lw_en),
        .mem_rdata          (mem_rdata),
        .mem_rdata_valid    (mem_rdata_valid),
        .rs1_f              (rs1_f),
        .rs2_f              (rs2_f),
        .rs3_f              (rs3_f),
        .rs1_data_f         (rs1_data_f),
        .rs2_data_f         (rs2_data_f),
        .rs3_data_f         (rs3_data_f),
        .stall_wb           (stall_wb),
        .fwd_valid          (fwd_valid),
        .fwd_rd             (fwd_rd),
        .fwd_data           (fwd_data),
        .load_err           (load_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_enable_f_out_wb = 1'b0;
        lw_en              = 1'b0;
        rd_temp_f_out_wb   = '0;
        result_f_wb        = '0;
        mem_rdata          = '0;
        mem_rdata_valid    = 1'b0;
    endtask

    // Value a read port should show, given the write (if any) landing at the next edge.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit act,
                                             input logic [4:0] wrd, input logic [31:0] wd);
        if (BYPASS && act && (a == wrd)) return wd;
        return exp_rf[a];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rs1_f = '0; rs2_f = '0; rs3_f = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        #1;
        checks++;
        if (stall_wb !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall_wb); end
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %0b want 0", load_err); end
        checks++;
        if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'd0) begin
            errors++; $display("FAIL reset_fwd got v=%0b rd=%0d d=%h want all zero", fwd_valid, fwd_rd, fwd_data);
        end
        for (int i = 0; i < 32; i++) begin
            rs1_f = 5'(i); rs2_f = 5'(31 - i); rs3_f = 5'(i);
            #1;
            checks++;
            if (rs1_data_f !== 32'd0 || rs2_data_f !== 32'd0 || rs3_data_f !== 32'd0) begin
                errors++;
                $display("FAIL reset_rf f%0d got %h/%h/%h want 0", i, rs1_data_f, rs2_data_f, rs3_data_f);
            end
        end
    endtask

    task automatic test_basic_write();
        wb_enable_f_out_wb = 1'b1; lw_en = 1'b0; rd_temp_f_out_wb = 5'd5;
        result_f_wb = 32'h3F80_0000; rs1_f = 5'd5;
        #1;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h3F80_0000) begin
            errors++; $display("FAIL basic_fwd got v=%0b rd=%0d d=%h want 1/5/3f800000", fwd_valid, fwd_rd, fwd_data);
        end
        checks++;
        if (rs1_data_f !== exp_read(5'd5, 1'b1, 5'd5, 32'h3F80_0000)) begin
            errors++; $display("FAIL basic_same_cycle got %h want %h", rs1_data_f, exp_read(5'd5, 1'b1, 5'd5, 32'h3F80_0000));
        end
        tick();
        exp_rf[5] = 32'h3F80_0000;
        idle_inputs();
        #1;
        checks++;
        if (rs1_data_f !== 32'h3F80_0000) begin
            errors++; $display("FAIL basic_next_cycle got %h want 3f800000", rs1_data_f);
        end
    endtask

    task automatic test_random_commits();
        bit          act;
        logic [4:0]  wrd;
        logic [31:0] wd;
        for (int n = 0; n < 80; n++) begin
            wb_enable_f_out_wb = 1'($urandom_range(0, 1));
            lw_en              = 1'($urandom_range(0, 1));
            mem_rdata_valid    = lw_en ? 1'b1 : 1'($urandom_range(0, 1));
            rd_temp_f_out_wb   = 5'($urandom_range(0, 31));
            result_f_wb        = $urandom;
            mem_rdata          = $urandom;
            rs1_f = 5'($urandom_range(0, 31));
            rs2_f = (n % 4 == 0) ? rd_temp_f_out_wb : 5'($urandom_range(0, 31));
            rs3_f = 5'($urandom_range(0, 31));
            act = wb_enable_f_out_wb;
            wrd = act ? rd_temp_f_out_wb : 5'd0;
            wd  = !act ? 32'd0 : (lw_en ? mem_rdata : result_f_wb);
            #1;
            checks++;
            if (fwd_valid !== act || fwd_rd !== wrd || fwd_data !== wd) begin
                errors++;
                $display("FAIL rand_fwd[%0d] got v=%0b rd=%0d d=%h want v=%0b rd=%0d d=%h",
                         n, fwd_valid, fwd_rd, fwd_data, act, wrd, wd);
            end
            checks++;
            if (rs1_data_f !== exp_read(rs1_f, act, wrd, wd) || rs2_data_f !== exp_read(rs2_f, act, wrd, wd) ||
                rs3_data_f !== exp_read(rs3_f, act, wrd, wd)) begin
                errors++;
                $display("FAIL rand_read[%0d] got %h/%h/%h want %h/%h/%h", n, rs1_data_f, rs2_data_f, rs3_data_f,
                         exp_read(rs1_f, act, wrd, wd), exp_read(rs2_f, act, wrd, wd), exp_read(rs3_f, act, wrd, wd));
            end
            checks++;
            if (stall_wb !== 1'b0) begin errors++; $display("FAIL rand_stall[%0d] got 1 want 0", n); end
            tick();
            if (act) exp_rf[wrd] = wd;
        end
        idle_inputs();
    endtask

    task automatic test_load_wait();
        int stalls = 0;
        idle_inputs();
        wb_enable_f_out_wb = 1'b1; lw_en = 1'b1; rd_temp_f_out_wb = 5'd7;
        #1;
        checks++;
        if (stall_wb !== 1'b0 || fwd_valid !== 1'b0) begin
            errors++; $display("FAIL load_issue got stall=%0b fwd_v=%0b want 0/0", stall_wb, fwd_valid);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            // Stage inputs wander during the stall and must be ignored.
            wb_enable_f_out_wb = 1'b1;
            lw_en              = 1'($urandom_range(0, 1));
            rd_temp_f_out_wb   = 5'($urandom_range(10, 31));
            result_f_wb        = $urandom;
            mem_rdata          = $urandom;
            #1;
            if (stall_wb === 1'b1) stalls++;
            checks++;
            if (fwd_valid !== 1'b0) begin errors++; $display("FAIL load_wait_fwd[%0d] got 1 want 0", k); end
            tick();
        end
        mem_rdata_valid  = 1'b1;
        mem_rdata        = 32'h4049_0FDB;
        rd_temp_f_out_wb = 5'd20;
        result_f_wb      = 32'hDEAD_BEEF;
        rs1_f            = 5'd7;
        #1;
        checks++;
        if (stalls != 3) begin errors++; $display("FAIL load_stall_cycles got %0d want 3", stalls); end
        checks++;
        if (stall_wb !== 1'b0) begin errors++; $display("FAIL load_stall_drop got 1 want 0"); end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'h4049_0FDB) begin
            errors++; $display("FAIL load_fwd got v=%0b rd=%0d d=%h want 1/7/40490fdb", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
        exp_rf[7] = 32'h4049_0FDB;
        idle_inputs();
        #1;
        checks++;
        if (rs1_data_f !== 32'h4049_0FDB) begin errors++; $display("FAIL load_rf7 got %h want 40490fdb", rs1_data_f); end
        rs1_f = 5'd20;
        #1;
        checks++;
        if (rs1_data_f !== exp_rf[20]) begin errors++; $display("FAIL load_ignored_rd got %h want %h", rs1_data_f, exp_rf[20]); end
    endtask

    task automatic test_timeout();
        int stalls = 0;
        idle_inputs();
        wb_enable_f_out_wb = 1'b1; lw_en = 1'b1; rd_temp_f_out_wb = 5'd3;
        tick();
        idle_inputs();
        // Limit is held for one cycle before the abort, so the stall spans LT+1 cycles.
        for (int k = 0; k < 20; k++) begin
            #1;
            if (stall_wb !== 1'b1) break;
            stalls++;
            checks++;
            if (load_err !== 1'b0 || fwd_valid !== 1'b0) begin
                errors++; $display("FAIL timeout_early[%0d] got err=%0b fwd_v=%0b want 0/0", k, load_err, fwd_valid);
            end
            tick();
        end
        checks++;
        if (stalls != int'(LT) + 1) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", stalls, LT + 1); end
        checks++;
        if (load_err !== 1'b1 || stall_wb !== 1'b0) begin
            errors++; $display("FAIL timeout_flag got err=%0b stall=%0b want 1/0", load_err, stall_wb);
        end
        for (int i = 0; i < 32; i++) begin
            rs3_f = 5'(i);
            #1;
            checks++;
            if (rs3_data_f !== exp_rf[i]) begin errors++; $display("FAIL timeout_rf f%0d got %h want %h", i, rs3_data_f, exp_rf[i]); end
        end
        wb_enable_f_out_wb = 1'b1; rd_temp_f_out_wb = 5'd3; result_f_wb = 32'h1234_5678;
        #1;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd3) begin
            errors++; $display("FAIL timeout_idle got fwd_v=%0b rd=%0d want 1/3", fwd_valid, fwd_rd);
        end
        tick();
        exp_rf[3] = 32'h1234_5678;
        idle_inputs();
        #1;
        checks++;
        if (load_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky got 0 want 1"); end
    endtask

    task automatic test_reset_in_wait();
        idle_inputs();
        wb_enable_f_out_wb = 1'b1; lw_en = 1'b1; rd_temp_f_out_wb = 5'd12;
        tick();
        idle_inputs();
        rst = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = 32'hA5A5_5A5A;
        #1;
        checks++;
        if (fwd_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_fwd got 1 want 0"); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) exp_rf[i] = '0;
        #1;
        checks++;
        if (fwd_valid !== 1'b0 || stall_wb !== 1'b0 || load_err !== 1'b0) begin
            errors++; $display("FAIL rst_wait_state got fwd_v=%0b stall=%0b err=%0b want 0/0/0", fwd_valid, stall_wb, load_err);
        end
        for (int i = 0; i < 32; i++) begin
            rs2_f = 5'(i);
            #1;
            checks++;
            if (rs2_data_f !== 32'd0) begin errors++; $display("FAIL rst_wait_rf f%0d got %h want 0", i, rs2_data_f); end
        end
        idle_inputs();
    endtask

    task automatic test_multi_read();
        wb_enable_f_out_wb = 1'b1; lw_en = 1'b0; rd_temp_f_out_wb = 5'd9; result_f_wb = 32'hC000_0000;
        rs1_f = 5'd9; rs2_f = 5'd9; rs3_f = 5'd9;
        #1;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd9 || fwd_data !== 32'hC000_0000) begin
            errors++; $display("FAIL multi_fwd got v=%0b rd=%0d d=%h want 1/9/c0000000", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
        exp_rf[9] = 32'hC000_0000;
        idle_inputs();
        #1;
        checks++;
        if (rs1_data_f !== 32'hC000_0000 || rs2_data_f !== 32'hC000_0000 || rs3_data_f !== 32'hC000_0000) begin
            errors++; $display("FAIL multi_read got %h/%h/%h want c0000000", rs1_data_f, rs2_data_f, rs3_data_f);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  r = 5'($urandom_range(0, 31));
        logic [31:0] a = $urandom;
        logic [31:0] b = $urandom ^ 32'h8000_0001;
        wb_enable_f_out_wb = 1'b1; lw_en = 1'b0; rd_temp_f_out_wb = r; result_f_wb = a; rs1_f = r;
        tick();
        exp_rf[r] = a;
        lw_en = 1'b1; mem_rdata_valid = 1'b1; mem_rdata = b; result_f_wb = $urandom;
        #1;
        checks++;
        if (fwd_valid !== 1'b1 || fwd_data !== b) begin
            errors++; $display("FAIL b2b_fwd got v=%0b d=%h want 1/%h", fwd_valid, fwd_data, b);
        end
        checks++;
        if (rs1_data_f !== exp_read(r, 1'b1, r, b)) begin
            errors++; $display("FAIL b2b_same_cycle got %h want %h", rs1_data_f, exp_read(r, 1'b1, r, b));
        end
        tick();
        exp_rf[r] = b;
        idle_inputs();
        #1;
        checks++;
        if (rs1_data_f !== b) begin errors++; $display("FAIL b2b_last_wins got %h want %h", rs1_data_f, b); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        rs1_f = '0; rs2_f = '0; rs3_f = '0;
        #1;
        test_reset();
        test_basic_write();
        test_random_commits();
        test_load_wait();
        test_timeout();
        test_reset_in_wait();
        test_multi_read();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_wb_stage.md
# fpu_wb_stage

Floating-point writeback stage and FP register file (f0–f31) of the RV32IF pipeline. Sits directly downstream of the FPU memory stage: it consumes that stage's registered destination, write-enable, result and load flag, merges in data-memory read data for FLW, and commits to the register file. It also services the decode stage's FP operand reads and stalls the pipeline while a load waits on memory.

## Interface
Parameters:
- LOAD_TIMEOUT, 255: cycles allowed in LOAD_WAIT before abort; range 1–255.

Ports:
- clk  input  1  pipeline clock; everything updates on its rising edge
- rst  input  1  synchronous, active-high reset
- rd_temp_f_out_wb  input  5  destination FP register
- wb_enable_f_out_wb  input  1  commit request this cycle
- result_f_wb  input  32  FPU result for non-load ops
- lw_en  input  1  qualifies the request as FLW; meaningful only when wb_enable_f_out_wb=1
- mem_rdata  input  32  data-memory read data
- mem_rdata_valid  input  1  mem_rdata valid this cycle
- rs1_f, rs2_f, rs3_f  input  5 each  read addresses (rs3 for fused multiply-add)
- rs1_data_f, rs2_data_f, rs3_data_f  output  32 each  read data
- stall_wb  output  1  upstream holds all stage inputs while high
- fwd_valid  output  1  write port active this cycle
- fwd_rd  output  5  write-port address
- fwd_data  output  32  write-port data
- load_err  output  1  sticky load-timeout flag

## Operation
- 32×32 register file; f0 is an ordinary writable register, not hardwired to zero.
- FSM states: IDLE, LOAD_WAIT.
- IDLE, wb_enable=0: no write.
- IDLE, wb_enable=1, lw_en=0: write result_f_wb to RF[rd] at the edge.
- IDLE, wb_enable=1, lw_en=1, mem_rdata_valid=1: write mem_rdata to RF[rd]; stay in IDLE.
- IDLE, wb_enable=1, lw_en=1, mem_rdata_valid=0: latch rd into pend_rd, clear timeout counter, go to LOAD_WAIT.
- LOAD_WAIT: stage inputs are ignored. When mem_rdata_valid=1, write mem_rdata to RF[pend_rd] and go to IDLE. Otherwise increment the 8-bit counter; when it reaches LOAD_TIMEOUT, set load_err, go to IDLE, and perform no write.
- stall_wb = (state==LOAD_WAIT) && !mem_rdata_valid (combinational).
- fwd_valid/fwd_rd/fwd_data are combinational and mirror exactly the write being committed at the coming edge. They are zero when no write occurs.
- Reads are asynchronous, from stored contents, except where the bypass option below is compiled in.

## Timing
- Reset (sync): all 32 RF entries, pend_rd and the counter go to 0. State goes to IDLE and load_err to 0. stall_wb, fwd_* and read outputs then follow from this zeroed state.
- Reset asserted during LOAD_WAIT abandons the pending load; no write occurs, even if mem_rdata_valid is high in the same cycle.
- Non-load commit latency: 1 edge; a write at edge N is readable from the array after N.
- A load whose data is valid in the same cycle behaves identically to a non-load commit.
- A load waiting k cycles holds stall_wb high for k cycles. stall_wb drops combinationally in the cycle mem_rdata_valid rises, and the write lands on that edge.
- The counter saturates at LOAD_TIMEOUT, and load_err asserts on the following edge.
- Back-to-back commits to the same rd: the last write wins.
- Multiple read ports may hit the same register simultaneously with no restriction.

## Configuration
- FPU_WB_BYPASS_EN defined: any rsN_f equal to fwd_rd while fwd_valid=1 returns fwd_data in the same cycle (write-through).
- FPU_WB_BYPASS_EN undefined: reads return the pre-write value, and the new value is visible the next cycle. Decode must then insert one bubble for that hazard.

## Test plan
- Reset, then read f0/f31 -> 0; stall_wb=0; load_err=0.
- wb_enable=1, lw_en=0, rd=5, result=0x3F800000; next cycle rs1_f=5 -> 0x3F800000. With the macro, the same-cycle read also returns 0x3F800000; without it, the read returns 0.
- FLW rd=7 with mem_rdata_valid low for 3 cycles, then valid with 0x40490FDB -> stall_wb high for exactly 3 cycles; then RF[7]=0x40490FDB. Changed stage inputs during the stall are ignored.
- FLW, never valid, LOAD_TIMEOUT=4 -> load_err=1 after timeout; RF unchanged; state IDLE; stall_wb=0.
- rst pulsed during LOAD_WAIT with mem_rdata_valid=1 -> no write; all registers 0.
- Three reads of rs1=rs2=rs3=9 after writing 0xC0000000 -> all three outputs return 0xC0000000; fwd_rd=9 during the write cycle.
